spi_config_bank: RTL and testbench

//  Multi-channel SPI configuration register bank with per-channel polarity, phase and speed.
//  Bus writes land in shadow registers; they commit to active registers only while the SPI engine is idle.

---
 rtl/spi_cfg_pkg.sv | 13 +
 rtl/spi_sclk_divider.sv | 26 ++
 rtl/spi_config_bank.sv | 61 ++++++
 tb/tb_spi_config_bank.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared SPI channel config type, data_in/bus_out field positions and reset value
package spi_cfg_pkg;
  localparam int CFG_SPEED_W = 4;
  localparam int SPEED_LSB = 0;
  localparam int POL_BIT = CFG_SPEED_W;
  localparam int PHASE_BIT = CFG_SPEED_W + 1;
  typedef struct packed {
    logic phase;
    logic polarity;
    logic [CFG_SPEED_W-1:0] speed;
  } spi_cfg_t;
  localparam spi_cfg_t SPI_CFG_RESET = '0;
endpackage

// File: rtl/spi_sclk_divider.sv
// spi_sclk_divider: counts while enable is high and pulses tick for one clk each time count reaches speed (clk, reset_L, enable, speed -> tick)
module spi_sclk_divider #(
  parameter int SPEED_W = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               enable,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick
);
  logic [SPEED_W-1:0] count;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count >= speed) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
endmodule

// File: rtl/spi_config_bank.sv
// spi_config_bank: per-channel SPI config bank (bus writes -> shadow, idle commit -> active, muxed to engine/readback, sclk tick)
module spi_config_bank
  import spi_cfg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SPEED_W = CFG_SPEED_W,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               wr_L,
  input  logic               config_select_L,
  input  logic               set_inhibit,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  bus_out,
  output logic [NUM_CH-1:0]  pending_out,
  input  logic [ADDR_W-1:0]  chan_sel,
  input  logic               engine_busy,
  output logic               serclk_polarity_out,
  output logic               serclk_phase_out,
  output logic [SPEED_W-1:0] serclk_speed_out,
  output logic               sclk_tick
);
  spi_cfg_t shadow [NUM_CH];
  spi_cfg_t active [NUM_CH];
  spi_cfg_t cur;
  logic we;
  logic unused_data;
  assign unused_data = ^data_in;
  assign we = !wr_L && !config_select_L && !set_inhibit;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= SPI_CFG_RESET;
        active[i] <= SPI_CFG_RESET;
      end
      pending_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!engine_busy && pending_out[i]) active[i] <= shadow[i];
        if (we && int'(addr) == i) begin
          shadow[i]      <= spi_cfg_t'(data_in[SPEED_W+1:0]);
          pending_out[i] <= 1'b1;
        end else if (!engine_busy) pending_out[i] <= 1'b0;
      end
    end
  assign cur = (int'(chan_sel) < NUM_CH) ? active[chan_sel] : SPI_CFG_RESET;
  assign bus_out = (int'(addr) < NUM_CH) ? DATA_W'(active[addr]) : '0;
  assign serclk_polarity_out = cur.polarity;
  assign serclk_phase_out = cur.phase;
  assign serclk_speed_out = cur.speed;
  spi_sclk_divider #(.SPEED_W(SPEED_W)) u_div (
    .clk     (clk),
    .reset_L (reset_L),
    .enable  (engine_busy),
    .speed   (serclk_speed_out),
    .tick    (sclk_tick)
  );
endmodule

// File: tb/tb_spi_config_bank.sv
// tb_spi_config_bank: directed self-checking bench for spi_config_bank
module tb_spi_config_bank;
  logic clk = 1'b0;
  logic reset_L, wr_L, config_select_L, set_inhibit, engine_busy;
  logic [1:0] addr, chan_sel;
  logic [7:0] data_in, bus_out;
  logic [3:0] pending_out, serclk_speed_out;
  logic serclk_polarity_out, serclk_phase_out, sclk_tick;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  spi_config_bank dut (
    .clk                 (clk),
    .reset_L             (reset_L),
    .wr_L                (wr_L),
    .config_select_L     (config_select_L),
    .set_inhibit         (set_inhibit),
    .addr                (addr),
    .data_in             (data_in),
    .bus_out             (bus_out),
    .pending_out         (pending_out),
    .chan_sel            (chan_sel),
    .engine_busy         (engine_busy),
    .serclk_polarity_out (serclk_polarity_out),
    .serclk_phase_out    (serclk_phase_out),
    .serclk_speed_out    (serclk_speed_out),
    .sclk_tick           (sclk_tick)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    addr = a;
    data_in = d;
    wr_L = 1'b0;
    config_select_L = 1'b0;
  endtask
  task automatic bus_idle();
    wr_L = 1'b1;
    config_select_L = 1'b1;
    set_inhibit = 1'b0;
  endtask
  initial begin
    reset_L = 1'b0;
    bus_idle();
    engine_busy = 1'b0;
    addr = '0;
    chan_sel = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    chk("reset_pending", 32'(pending_out), 32'h0);
    chk("reset_tick", 32'(sclk_tick), 32'h0);
    chk("reset_speed", 32'(serclk_speed_out), 32'h0);
    bus_wr(2'd0, 8'h2F);
    @(negedge clk);
    bus_idle();
    chk("pre_pending", 32'(pending_out), 32'h1);
    @(negedge clk);
    chk("pre_speed", 32'(serclk_speed_out), 32'hF);
    chk("pre_bus", 32'(bus_out), 32'h2F);
    engine_busy = 1'b1;
    bus_wr(2'd1, 8'h11);
    #2 reset_L = 1'b0;
    #1;
    chk("async_speed", 32'(serclk_speed_out), 32'h0);
    chk("async_bus", 32'(bus_out), 32'h0);
    chk("async_phase", 32'(serclk_phase_out), 32'h0);
    chk("async_pending", 32'(pending_out), 32'h0);
    chk("async_tick", 32'(sclk_tick), 32'h0);
    @(negedge clk);
    reset_L = 1'b1;
    engine_busy = 1'b0;
    bus_idle();
    chan_sel = 2'd2;
    bus_wr(2'd2, 8'h2A);
    @(negedge clk);
    bus_idle();
    chk("idle_pending", 32'(pending_out), 32'h4);
    chk("idle_speed_before", 32'(serclk_speed_out), 32'h0);
    @(negedge clk);
    chk("idle_pending_clr", 32'(pending_out), 32'h0);
    chk("idle_speed", 32'(serclk_speed_out), 32'hA);
    chk("idle_phase", 32'(serclk_phase_out), 32'h1);
    chk("idle_pol", 32'(serclk_polarity_out), 32'h0);
    chk("idle_bus", 32'(bus_out), 32'h2A);
    engine_busy = 1'b1;
    chan_sel = 2'd1;
    bus_wr(2'd1, 8'h13);
    @(negedge clk);
    bus_idle();
    chk("busy_pending", 32'(pending_out), 32'h2);
    chk("busy_speed", 32'(serclk_speed_out), 32'h0);
    @(negedge clk);
    chk("busy_pending_hold", 32'(pending_out), 32'h2);
    chk("busy_bus", 32'(bus_out), 32'h0);
    engine_busy = 1'b0;
    @(negedge clk);
    chk("busy_commit_pending", 32'(pending_out), 32'h0);
    chk("busy_commit_speed", 32'(serclk_speed_out), 32'h3);
    chk("busy_commit_pol", 32'(serclk_polarity_out), 32'h1);
    chk("busy_commit_phase", 32'(serclk_phase_out), 32'h0);
    chk("busy_commit_bus", 32'(bus_out), 32'h13);
    bus_wr(2'd3, 8'h3F);
    set_inhibit = 1'b1;
    @(negedge clk);
    bus_idle();
    chk("inhibit_pending", 32'(pending_out), 32'h0);
    chk("inhibit_bus", 32'(bus_out), 32'h0);
    addr = 2'd3;
    data_in = 8'h3F;
    wr_L = 1'b0;
    @(negedge clk);
    bus_idle();
    chk("nosel_pending", 32'(pending_out), 32'h0);
    engine_busy = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("div3_c%0d", k), 32'(sclk_tick), (k % 4 == 0) ? 32'h1 : 32'h0);
    end
    chan_sel = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("div0_c%0d", k), 32'(sclk_tick), 32'h1);
    end
    engine_busy = 1'b0;
    @(negedge clk);
    chk("div_stop", 32'(sclk_tick), 32'h0);
    chan_sel = 2'd1;
    engine_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("div_restart_c%0d", k), 32'(sclk_tick), (k == 4) ? 32'h1 : 32'h0);
    end
    chan_sel = 2'd0;
    bus_wr(2'd0, 8'h01);
    @(negedge clk);
    chk("same_pending_busy", 32'(pending_out), 32'h1);
    engine_busy = 1'b0;
    bus_wr(2'd0, 8'h05);
    @(negedge clk);
    bus_idle();
    chk("same_old_speed", 32'(serclk_speed_out), 32'h1);
    chk("same_pending_kept", 32'(pending_out), 32'h1);
    @(negedge clk);
    chk("same_new_speed", 32'(serclk_speed_out), 32'h5);
    chk("same_pending_clr", 32'(pending_out), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
